// File: rtl/niosii_cpu_mult_pipe_if.sv
// niosii_cpu_mult_pipe_if: issue/result bundle between the execute stage and the multiply unit.
interface niosii_cpu_mult_pipe_if #(
    parameter int DATA_W = 32,
    parameter int TAG_W  = 5
);
    logic              en;
    logic              flush;
    logic              in_valid;
    logic [1:0]        in_op;
    logic [DATA_W-1:0] in_src1;
    logic [DATA_W-1:0] in_src2;
    logic [TAG_W-1:0]  in_tag;
    logic              out_valid;
    logic [DATA_W-1:0] out_result;
    logic [TAG_W-1:0]  out_tag;
    logic              busy;
    modport master (
        output en, flush, in_valid, in_op, in_src1, in_src2, in_tag,
        input  out_valid, out_result, out_tag, busy
    );
    modport slave (
        input  en, flush, in_valid, in_op, in_src1, in_src2, in_tag,
        output out_valid, out_result, out_tag, busy
    );
endinterface

// File: rtl/niosii_cpu_mult_pipe.sv
// niosii_cpu_mult_pipe: pipelined Nios II multiply (MUL/MULXSS/MULXSU/MULXUU) with tag, stall and flush.
module niosii_cpu_mult_pipe #(
    parameter int DATA_W = 32,
    parameter int TAG_W  = 5,
    parameter int STAGES = 2
) (
    input logic clk,
    input logic reset,
    niosii_cpu_mult_pipe_if.slave bus
);
    localparam int L = DATA_W / 16;
    localparam int P = L * L;
    logic [31:0]         pp_c [P];
    logic [31:0]         pp_s [P];
    logic [DATA_W-1:0]   corr_c;
    logic [DATA_W-1:0]   corr_s;
    logic                lo_s;
    logic [TAG_W-1:0]    tag_s;
    logic                v_s;
    logic [2*DATA_W-1:0] prod;
    logic [DATA_W-1:0]   res_s;
    logic                v_f;
    logic [TAG_W-1:0]    tag_f;
    logic [DATA_W-1:0]   res_f;
    logic                busy_p;
    // Unsigned limb products; signed forms are fixed up by subtracting the other operand from the high half.
    always_comb begin
        for (int i = 0; i < L; i++)
            for (int j = 0; j < L; j++)
                pp_c[i*L+j] = 32'(bus.in_src1[16*i +: 16]) * 32'(bus.in_src2[16*j +: 16]);
        corr_c = (((bus.in_op[0] ^ bus.in_op[1]) && bus.in_src1[DATA_W-1]) ? bus.in_src2 : '0)
               + ((bus.in_op == 2'd1 && bus.in_src2[DATA_W-1]) ? bus.in_src1 : '0);
    end
    always_comb begin
        prod = '0;
        for (int i = 0; i < L; i++)
            for (int j = 0; j < L; j++)
                prod = prod + ((2*DATA_W)'(pp_s[i*L+j]) << (16*(i+j)));
        res_s = lo_s ? prod[DATA_W-1:0] : prod[2*DATA_W-1:DATA_W] - corr_s;
    end
    if (STAGES == 1) begin : g_s1_comb
        assign pp_s   = pp_c;
        assign corr_s = corr_c;
        assign lo_s   = bus.in_op == 2'd0;
        assign tag_s  = bus.in_tag;
        assign v_s    = bus.in_valid;
    end else begin : g_s1_reg
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                pp_s   <= '{default: '0};
                corr_s <= '0;
                lo_s   <= 1'b0;
                tag_s  <= '0;
                v_s    <= 1'b0;
            end else begin
                v_s <= !bus.flush && (bus.en ? bus.in_valid : v_s);
                if (bus.en) begin
                    pp_s   <= pp_c;
                    corr_s <= corr_c;
                    lo_s   <= bus.in_op == 2'd0;
                    tag_s  <= bus.in_tag;
                end
            end
        end
    end
    if (STAGES == 3) begin : g_mid
        logic              v_m;
        logic [TAG_W-1:0]  tag_m;
        logic [DATA_W-1:0] res_m;
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                v_m   <= 1'b0;
                tag_m <= '0;
                res_m <= '0;
            end else begin
                v_m <= !bus.flush && (bus.en ? v_s : v_m);
                if (bus.en) begin
                    tag_m <= tag_s;
                    res_m <= res_s;
                end
            end
        end
        assign v_f    = v_m;
        assign tag_f  = tag_m;
        assign res_f  = res_m;
        assign busy_p = v_s | v_m;
    end else begin : g_nomid
        assign v_f    = v_s;
        assign tag_f  = tag_s;
        assign res_f  = res_s;
        assign busy_p = (STAGES > 1) && v_s;
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus.out_valid  <= 1'b0;
            bus.out_result <= '0;
            bus.out_tag    <= '0;
        end else begin
            bus.out_valid <= !bus.flush && (bus.en ? v_f : bus.out_valid);
            if (bus.en) begin
                bus.out_result <= res_f;
                bus.out_tag    <= tag_f;
            end
        end
    end
    assign bus.busy = busy_p | bus.out_valid;
endmodule

// File: doc/niosii_cpu_mult_pipe.md
Name: niosii_cpu_mult_pipe

Overview:
- Parametrised, pipelined integer multiply unit for the CPU execute/memory path.
- Replaces the fixed three-cell 16x16 partial-product arrangement with one block that produces the full product.
- Supports the four Nios II multiply forms: low word, signed×signed high, signed×unsigned high, unsigned×unsigned high.
- Adds a valid/tag pipeline, a stall enable, a flush and a busy indication, so in-flight operations are tracked by the unit itself.

Parameters:
- DATA_W, 32: operand and result width; multiple of 16, range 16..64.
- TAG_W, 5: width of the sideband tag (destination register index) carried with each operation.
- STAGES, 2: pipeline latency in cycles; range 1..3.

Ports:
- clk  in  1  clock; all state on rising edge.
- reset  in  1  asynchronous, active-high reset.
- en  in  1  pipeline advance enable; 0 = hold every stage (stall).
- flush  in  1  discard all in-flight operations.
- in_valid  in  1  operation presented this cycle.
- in_op  in  2  0=MUL (low word), 1=MULXSS, 2=MULXSU, 3=MULXUU.
- in_src1  in  DATA_W  operand A (signed for MULXSS/MULXSU).
- in_src2  in  DATA_W  operand B (signed for MULXSS only).
- in_tag  in  TAG_W  sideband tag, returned unchanged.
- out_valid  out  1  result valid.
- out_result  out  DATA_W  selected result word.
- out_tag  out  TAG_W  tag of the result.
- busy  out  1  OR of all stage valid bits.

Behaviour:
- Reset (asynchronous, active-high):
  - All stage valid bits, data and tag registers clear to 0 immediately.
  - Outputs during and after reset: out_valid=0, out_result=0, out_tag=0, busy=0.
  - Any operation in flight when reset asserts is lost; no completion is reported for it.
- Arithmetic:
  - A is extended to DATA_W+1 bits: sign-extended for op 1 and op 2, zero-extended otherwise.
  - B is extended to DATA_W+1 bits: sign-extended for op 1 only.
  - P = exact 2*DATA_W-bit two's-complement product of the extended operands.
  - Op 0 returns P[DATA_W-1:0], identical for signed and unsigned operands (wraps modulo 2^DATA_W).
  - Ops 1-3 return P[2*DATA_W-1:DATA_W].
  - Internal decomposition into 16x16 limb products is free, but the first stage register must sit after the limb multipliers so they map to DSP input/output registers.
- Pipeline and handshake:
  - An operation is accepted when in_valid=1 and en=1 and flush=0. The unit never back-pressures.
  - Accepted op appears with out_valid=1 exactly STAGES en-high cycles later. Cycles with en=0 do not count.
  - out_valid, out_result and out_tag are registered outputs.
  - out_valid is high for exactly one en-high cycle per accepted op. Results leave in acceptance order.
  - en=0: every register holds, including the outputs. in_valid is ignored and that input is not accepted.
  - A result held during a stall stays visible with out_valid=1 until the next en-high edge.
- Flush:
  - flush=1 at an edge clears all stage valid bits and out_valid, regardless of en.
  - A simultaneous in_valid is dropped.
  - Data and tag registers may keep stale values but must be qualified by valid.
  - busy=0 on the cycle after flush. flush has priority over en and in_valid.
- busy is combinational OR of stage valids and out_valid; it is high when any op is in flight or pending at the output.
- Boundary conditions:
  - Back-to-back accepts every cycle give one result per cycle.
  - Ops 1-3 with DATA_W=16 must still produce the correct high half.
  - Most-negative operand cases (0x8000_0000 × 0x8000_0000, signed) must not overflow, because the product is computed at 2*DATA_W bits.
  - Deassertion of reset is synchronised externally; the block assumes a clean release.

Test Plan:
- DATA_W=32, STAGES=2: MUL 0x0000_0007 × 0x0000_0006, tag 5, en=1 -> after 2 cycles out_valid=1, out_result=0x0000_002A, out_tag=5, for one cycle only.
- Src 0xFFFF_FFFF × 0xFFFF_FFFF, issued back-to-back:
  - MULXSS -> 0x0000_0000.
  - MULXUU -> 0xFFFF_FFFE.
  - MULXSU -> 0xFFFF_FFFF.
  - MUL -> 0x0000_0001.
  - Results arrive on 4 consecutive cycles in issue order.
- MUL 0x8000_0000 × 2 -> 0x0000_0000; MULXSS 0x8000_0000 × 0x8000_0000 -> 0x4000_0000.
- Issue tags 1-4 back-to-back and drop en for 3 cycles after the 2nd accept:
  - Output registers stay frozen during the stall.
  - Tags 1-4 each appear exactly once, in order.
  - The in_valid presented while en=0 is not accepted.
- Two ops in flight, then flush=1 together with a new in_valid -> no out_valid for the next 4 cycles; busy=0 one cycle after flush.
- Assert reset asynchronously between clock edges with 2 ops in flight:
  - out_valid, busy and out_result go to 0 before the next edge.
  - After release, a new MUL 3×3 returns 9 with latency 2.
  - Repeat for STAGES=1 and STAGES=3, checking latency 1 and 3 respectively.
